// File: rtl/decoder_2x4_seq_if.sv
// Handshake and readback bundle for the registered 2-to-4 decoder.
// slave is the decoder side; master is the side that supplies indices
// and reads the hit counters.
interface decoder_2x4_seq_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [1:0]       in_idx;
  logic             in_ready;
  logic [3:0]       y;
  logic             y_valid;
  logic             busy;
  logic [1:0]       cnt_sel;
  logic [CNT_W-1:0] cnt_out;

  modport slave (
    input  in_valid, in_idx, cnt_sel,
    output in_ready, y, y_valid, busy, cnt_out
  );

  modport master (
    output in_valid, in_idx, cnt_sel,
    input  in_ready, y, y_valid, busy, cnt_out
  );
endinterface

// File: rtl/decoder_2x4_seq.sv
// Registered 2-to-4 decoder: turns an accepted index into a one-hot pulse
// lasting HOLD cycles, then idles GAP cycles before taking the next index.
// Keeps a saturating hit counter per index.
//
// state  | meaning
// IDLE   | in_ready high, y low, waiting for an index
// ACTIVE | one-hot line driven; timer counts the remaining hold cycles
// GAP    | y low, timer counts the remaining idle cycles before IDLE
module decoder_2x4_seq #(
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  decoder_2x4_seq_if.slave  bus
);

  localparam int TMAX  = (HOLD > GAP) ? HOLD : GAP;
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TMR_W-1:0] HOLD_M1 = TMR_W'(HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_M1  = TMR_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [3:0]       y_q, y_nxt;
  logic             y_valid_q;
  logic             accept;
  logic [CNT_W-1:0] hits [4];

  assign accept       = bus.in_valid && (state == S_IDLE);
  assign bus.in_ready = (state == S_IDLE);
  assign bus.busy     = (state != S_IDLE);
  assign bus.y        = y_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.cnt_out  = hits[bus.cnt_sel];

  // State register, hold/gap timer and registered one-hot output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      y_q       <= 4'b0000;
      y_valid_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      y_q       <= y_nxt;
      y_valid_q <= |y_nxt;
    end
  end

  // Next-state logic: load the timer on entry, leave on terminal count.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    y_nxt     = y_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          y_nxt     = 4'b0001 << bus.in_idx;
          tmr_nxt   = HOLD_M1;
          state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (tmr == '0) begin
          y_nxt = 4'b0000;
          if (GAP == 0) begin
            state_nxt = S_IDLE;
          end else begin
            tmr_nxt   = GAP_M1;
            state_nxt = S_GAP;
          end
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      S_GAP: begin
        if (tmr == '0) begin
          state_nxt = S_IDLE;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        y_nxt     = 4'b0000;
      end
    endcase
  end

  // Per-index hit counters; saturate at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hits[i] <= '0;
      end
    end else if (accept && (hits[bus.in_idx] != {CNT_W{1'b1}})) begin
      hits[bus.in_idx] <= hits[bus.in_idx] + CNT_W'(1);
    end
  end

endmodule
